// File: rtl/spdif_rx.sv
// S/PDIF (IEC 60958) biphase-mark receiver.
// Oversamples the line with clk, measures the time between edges, finds the
// B/M/W preambles and decodes 24-bit audio plus V/U/C/P for each subframe.
// A left (B/M) subframe followed by a right (W) subframe is delivered as one
// 48-bit stereo word, left in [47:24] and right in [23:0].
module spdif_rx #(
   parameter int UI_CLK      = 16,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_i,
   output logic [47:0] data_o,
   output logic        valid_o,
   output logic        blkstart_o,
   output logic [1:0]  vbits_o,
   output logic [1:0]  ubits_o,
   output logic [1:0]  cbits_o,
   output logic        parity_err_o,
   output logic        locked_o
);

   // Width counter saturates at 4 UI, which is already beyond any legal pulse.
   localparam int CNT_MAX = 4 * UI_CLK;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int LCW     = $clog2(LOCK_FRAMES + 1);

   // Class window boundaries sit halfway between nominal widths, so jitter of
   // just under half a UI either way still lands in the right class.
   localparam logic [CW-1:0] LIM_1UI  = CW'(UI_CLK / 2);
   localparam logic [CW-1:0] LIM_2UI  = CW'((3 * UI_CLK) / 2);
   localparam logic [CW-1:0] LIM_3UI  = CW'((5 * UI_CLK) / 2);
   localparam logic [CW-1:0] LIM_LONG = CW'((7 * UI_CLK) / 2);
   localparam logic [CW-1:0] CNT_SAT  = CW'(CNT_MAX);

   localparam logic [2:0] CLS_GLITCH = 3'd0;
   localparam logic [2:0] CLS_1UI    = 3'd1;
   localparam logic [2:0] CLS_2UI    = 3'd2;
   localparam logic [2:0] CLS_3UI    = 3'd3;
   localparam logic [2:0] CLS_LONG   = 3'd4;

   localparam logic [1:0] ST_HUNT = 2'd0;
   localparam logic [1:0] ST_PRE  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   localparam logic [1:0] PRE_B = 2'd0;
   localparam logic [1:0] PRE_M = 2'd1;
   localparam logic [1:0] PRE_W = 2'd2;

   localparam logic [4:0] LAST_CELL = 5'd27;

   logic          rx_s1;
   logic          rx_s2;
   logic          rx_d;
   logic          edge_q;
   logic [CW-1:0] width_cnt;
   logic [2:0]    cls;

   logic [1:0]    state;
   logic [1:0]    pre_cnt;
   logic [2:0]    pre_h0;
   logic [2:0]    pre_h1;
   logic [1:0]    pre_type;
   logic [1:0]    pre_match;
   logic [4:0]    bit_idx;
   logic          half_q;
   logic          par_acc;
   logic [26:0]   sub_reg;

   logic [23:0]   left_audio;
   logic          left_v;
   logic          left_u;
   logic          left_c;
   logic          left_blk;
   logic          pend_left;
   logic [LCW-1:0] lock_cnt;

   logic          err;
   logic          pre_done;
   logic          bit_done;
   logic          bit_val;
   logic          sub_done;
   logic          par_bad;
   logic          fail;

   // Two-flop synchronizer for the asynchronous line, then a registered edge flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_s1  <= 1'b0;
         rx_s2  <= 1'b0;
         rx_d   <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         rx_s1  <= rx_i;
         rx_s2  <= rx_s1;
         rx_d   <= rx_s2;
         edge_q <= rx_s2 ^ rx_d;
      end
   end

   // Cycles since the previous edge; on an edge cycle it holds the finished width.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         width_cnt <= '0;
      end else if (edge_q) begin
         width_cnt <= CW'(1);
      end else if (width_cnt != CNT_SAT) begin
         width_cnt <= width_cnt + CW'(1);
      end
   end

   // Map the measured width onto glitch / 1UI / 2UI / 3UI / overlong.
   always_comb begin
      if (width_cnt < LIM_1UI) begin
         cls = CLS_GLITCH;
      end else if (width_cnt < LIM_2UI) begin
         cls = CLS_1UI;
      end else if (width_cnt < LIM_3UI) begin
         cls = CLS_2UI;
      end else if (width_cnt < LIM_LONG) begin
         cls = CLS_3UI;
      end else begin
         cls = CLS_LONG;
      end
   end

   // Per-edge decode: preamble matching, cell decoding and error detection.
   always_comb begin
      err       = 1'b0;
      pre_done  = 1'b0;
      pre_match = PRE_B;
      bit_done  = 1'b0;
      bit_val   = 1'b0;
      if (edge_q) begin
         case (state)
            ST_PRE: begin
               if (cls == CLS_GLITCH || cls == CLS_LONG) begin
                  err = 1'b1;
               end else if (pre_cnt == 2'd2) begin
                  if ({pre_h0, pre_h1, cls} == {CLS_1UI, CLS_1UI, CLS_3UI}) begin
                     pre_done  = 1'b1;
                     pre_match = PRE_B;
                  end else if ({pre_h0, pre_h1, cls} == {CLS_3UI, CLS_1UI, CLS_1UI}) begin
                     pre_done  = 1'b1;
                     pre_match = PRE_M;
                  end else if ({pre_h0, pre_h1, cls} == {CLS_2UI, CLS_1UI, CLS_2UI}) begin
                     pre_done  = 1'b1;
                     pre_match = PRE_W;
                  end else begin
                     err = 1'b1;
                  end
               end
            end
            ST_DATA: begin
               case (cls)
                  CLS_1UI: begin
                     if (half_q) begin
                        bit_done = 1'b1;
                        bit_val  = 1'b1;
                     end
                  end
                  CLS_2UI: begin
                     if (half_q) begin
                        err = 1'b1;
                     end else begin
                        bit_done = 1'b1;
                     end
                  end
                  default: err = 1'b1;
               endcase
            end
            default: begin
            end
         endcase
      end
   end

   assign sub_done     = bit_done && (bit_idx == LAST_CELL);
   assign par_bad      = sub_done && (par_acc ^ bit_val);
   assign fail         = err || par_bad;
   assign parity_err_o = par_bad;

   // Framing FSM: hunt for a 3UI pulse, match the preamble, then shift in 28 cells.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_HUNT;
         pre_cnt  <= 2'd0;
         pre_h0   <= CLS_GLITCH;
         pre_h1   <= CLS_GLITCH;
         pre_type <= PRE_B;
         bit_idx  <= 5'd0;
         half_q   <= 1'b0;
         par_acc  <= 1'b0;
         sub_reg  <= '0;
      end else if (fail) begin
         state   <= ST_HUNT;
         pre_cnt <= 2'd0;
         half_q  <= 1'b0;
      end else if (edge_q) begin
         case (state)
            ST_HUNT: begin
               if (cls == CLS_3UI) begin
                  state   <= ST_PRE;
                  pre_cnt <= 2'd0;
               end
            end
            ST_PRE: begin
               if (pre_cnt == 2'd0) begin
                  pre_h0  <= cls;
                  pre_cnt <= 2'd1;
               end else if (pre_cnt == 2'd1) begin
                  pre_h1  <= cls;
                  pre_cnt <= 2'd2;
               end else if (pre_done) begin
                  state    <= ST_DATA;
                  pre_type <= pre_match;
                  pre_cnt  <= 2'd0;
                  bit_idx  <= 5'd0;
                  half_q   <= 1'b0;
                  par_acc  <= 1'b0;
               end
            end
            ST_DATA: begin
               if (bit_done) begin
                  half_q  <= 1'b0;
                  par_acc <= par_acc ^ bit_val;
                  bit_idx <= bit_idx + 5'd1;
                  if (sub_done) begin
                     state <= ST_HUNT;
                  end else begin
                     sub_reg <= {bit_val, sub_reg[26:1]};
                  end
               end else begin
                  half_q <= 1'b1;
               end
            end
            default: state <= ST_HUNT;
         endcase
      end
   end

   // Pair left and right subframes, publish the stereo word and track lock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_o     <= '0;
         valid_o    <= 1'b0;
         blkstart_o <= 1'b0;
         vbits_o    <= 2'b00;
         ubits_o    <= 2'b00;
         cbits_o    <= 2'b00;
         locked_o   <= 1'b0;
         left_audio <= '0;
         left_v     <= 1'b0;
         left_u     <= 1'b0;
         left_c     <= 1'b0;
         left_blk   <= 1'b0;
         pend_left  <= 1'b0;
         lock_cnt   <= '0;
      end else begin
         valid_o <= 1'b0;
         if (fail) begin
            pend_left <= 1'b0;
            lock_cnt  <= '0;
            locked_o  <= 1'b0;
         end else if (sub_done) begin
            if (pre_type != PRE_W) begin
               left_audio <= sub_reg[23:0];
               left_v     <= sub_reg[24];
               left_u     <= sub_reg[25];
               left_c     <= sub_reg[26];
               left_blk   <= (pre_type == PRE_B);
               pend_left  <= 1'b1;
            end else if (pend_left) begin
               data_o     <= {left_audio, sub_reg[23:0]};
               vbits_o    <= {left_v, sub_reg[24]};
               ubits_o    <= {left_u, sub_reg[25]};
               cbits_o    <= {left_c, sub_reg[26]};
               blkstart_o <= left_blk;
               valid_o    <= 1'b1;
               pend_left  <= 1'b0;
               if (lock_cnt != LCW'(LOCK_FRAMES)) begin
                  lock_cnt <= lock_cnt + LCW'(1);
               end
               if (lock_cnt >= LCW'(LOCK_FRAMES - 1)) begin
                  locked_o <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spdif_rx.sv
// Scoreboard bench for spdif_rx: a biphase-mark line model drives directed
// frames, each expected stereo word is queued as it is sent, and a monitor
// pops and compares on every valid_o.
module tb_spdif_rx;

   localparam int UI = 16;

   localparam logic [1:0] PRE_B = 2'd0;
   localparam logic [1:0] PRE_M = 2'd1;
   localparam logic [1:0] PRE_W = 2'd2;

   typedef struct packed {
      logic [47:0] data;
      logic [1:0]  v;
      logic [1:0]  u;
      logic [1:0]  c;
      logic        blk;
      logic        lock;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rx_line = 1'b0;
   logic [47:0] data_o;
   logic        valid_o;
   logic        blkstart_o;
   logic [1:0]  vbits_o;
   logic [1:0]  ubits_o;
   logic [1:0]  cbits_o;
   logic        parity_err_o;
   logic        locked_o;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          good_frames = 0;
   int          exp_perr = 0;
   int          seen_perr = 0;
   logic [47:0] last_data = '0;

   spdif_rx #(.UI_CLK(UI), .LOCK_FRAMES(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_i         (rx_line),
      .data_o       (data_o),
      .valid_o      (valid_o),
      .blkstart_o   (blkstart_o),
      .vbits_o      (vbits_o),
      .ubits_o      (ubits_o),
      .cbits_o      (cbits_o),
      .parity_err_o (parity_err_o),
      .locked_o     (locked_o)
   );

   // 10 ns system clock.
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_output({tag, "_data"}, data_o, 0);
      check_output({tag, "_valid"}, valid_o, 0);
      check_output({tag, "_blk"}, blkstart_o, 0);
      check_output({tag, "_vuc"}, {vbits_o, ubits_o, cbits_o}, 0);
      check_output({tag, "_perr"}, parity_err_o, 0);
      check_output({tag, "_lock"}, locked_o, 0);
   endtask

   // One biphase pulse: toggle the line and hold it for w clocks.
   task automatic send_pulse(input int w);
      rx_line = ~rx_line;
      repeat (w) @(negedge clk);
   endtask

   // Asynchronous reset for two clocks, outputs checked before any clock edge.
   task automatic do_reset_pulse();
      #2 rst = 1'b0;
      #1 check_all_zero("async_reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic send_subframe(input logic [1:0] pre, input logic [23:0] d,
                                input logic v, input logic u, input logic c,
                                input bit flip_p, input int delta,
                                input int glitch_cell, input int reset_cell);
      logic [27:0] cells;
      cells     = {1'b0, c, u, v, d};
      cells[27] = (^cells[26:0]) ^ flip_p;
      send_pulse(3 * UI + delta);
      case (pre)
         PRE_B: begin
            send_pulse(UI + delta); send_pulse(UI + delta); send_pulse(3 * UI + delta);
         end
         PRE_M: begin
            send_pulse(3 * UI + delta); send_pulse(UI + delta); send_pulse(UI + delta);
         end
         default: begin
            send_pulse(2 * UI + delta); send_pulse(UI + delta); send_pulse(2 * UI + delta);
         end
      endcase
      for (int i = 0; i < 28; i++) begin
         if (i == glitch_cell) send_pulse(4);
         if (i == reset_cell) do_reset_pulse();
         if (cells[i]) begin
            send_pulse(UI + delta);
            send_pulse(UI + delta);
         end else begin
            send_pulse(2 * UI + delta);
         end
      end
   endtask

   // Queue the expected outcome of a frame, then put it on the line.
   task automatic send_frame(input logic [1:0] pre_l, input logic [23:0] l, input logic [23:0] r,
                             input logic [1:0] v, input logic [1:0] u, input logic [1:0] c,
                             input bit flip_p, input int delta,
                             input int glitch_cell, input int reset_cell);
      exp_t e;
      if (glitch_cell >= 0 || reset_cell >= 0) begin
         good_frames = 0;
      end else if (flip_p) begin
         good_frames = 0;
         exp_perr++;
      end else begin
         good_frames++;
         e.data = {l, r};
         e.v    = v;
         e.u    = u;
         e.c    = c;
         e.blk  = (pre_l == PRE_B);
         e.lock = (good_frames >= 2);
         exp_q.push_back(e);
         last_data = {l, r};
      end
      send_subframe(pre_l, l, v[1], u[1], c[1], 1'b0, delta, glitch_cell, reset_cell);
      send_subframe(PRE_W, r, v[0], u[0], c[0], flip_p, delta, -1, -1);
   endtask

   // Monitor: pop and compare on every valid_o, count parity error strobes.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (parity_err_o === 1'b1) seen_perr++;
         if (valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("[TB] FAIL unexpected_valid: got valid_o=1 data_o=%h, expected no valid", data_o);
            end else begin
               e = exp_q.pop_front();
               check_output("data", data_o, e.data);
               check_output("vbits", vbits_o, e.v);
               check_output("ubits", ubits_o, e.u);
               check_output("cbits", cbits_o, e.c);
               check_output("blkstart", blkstart_o, e.blk);
               check_output("locked", locked_o, e.lock);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      repeat (90000) @(posedge clk);
      $display("[TB] FAIL watchdog: got no end of stimulus, expected completion within 90000 cycles");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus sequence.
   initial begin
      rst     = 1'b0;
      rx_line = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;
      repeat (20) @(negedge clk);

      $display("[TB] basic frame, B then M preamble");
      send_frame(PRE_B, 24'h123456, 24'habcdef, 2'b00, 2'b00, 2'b00, 1'b0, 0, -1, -1);
      send_frame(PRE_M, 24'h123456, 24'habcdef, 2'b00, 2'b00, 2'b00, 1'b0, 0, -1, -1);

      $display("[TB] M frames with incrementing left and C_left set");
      for (int i = 0; i < 4; i++) begin
         send_frame(PRE_M, 24'(i), 24'hffffff, 2'b00, 2'b00, 2'b10, 1'b0, 0, -1, -1);
      end

      $display("[TB] parity flip in right subframe of frame 3");
      for (int i = 1; i <= 5; i++) begin
         send_frame(PRE_M, 24'h010203 * 24'(i), 24'h0f0f00 + 24'(i), 2'b01, 2'b10, 2'b00,
                    (i == 3), 0, -1, -1);
      end

      $display("[TB] glitch inside left data cells");
      send_frame(PRE_M, 24'h777777, 24'h888888, 2'b00, 2'b00, 2'b00, 1'b0, 0, 10, -1);
      check_output("glitch_hold", data_o, last_data);
      send_frame(PRE_B, 24'hc0ffee, 24'h00beef, 2'b11, 2'b00, 2'b01, 1'b0, 0, -1, -1);
      send_frame(PRE_M, 24'h800001, 24'h7ffffe, 2'b00, 2'b11, 2'b00, 1'b0, 0, -1, -1);

      $display("[TB] pulse widths stretched then shrunk");
      for (int i = 0; i < 8; i++) begin
         send_frame((i == 0) ? PRE_B : PRE_M, 24'h5a5a00 + 24'(i), 24'ha5a5ff - 24'(i),
                    2'(i), 2'(i + 1), 2'(i + 2), 1'b0, 7, -1, -1);
      end
      for (int i = 0; i < 8; i++) begin
         send_frame((i == 0) ? PRE_B : PRE_M, 24'h3c0000 + 24'(i * 3), 24'hc30000 + 24'(i * 5),
                    2'(i + 3), 2'(i), 2'(i + 1), 1'b0, -7, -1, -1);
      end

      $display("[TB] reset pulse inside left subframe");
      send_frame(PRE_M, 24'h999999, 24'h666666, 2'b00, 2'b00, 2'b00, 1'b0, 0, -1, 12);
      check_output("reset_hold_data", data_o, 0);
      send_frame(PRE_B, 24'h246802, 24'h135791, 2'b00, 2'b00, 2'b00, 1'b0, 0, -1, -1);
      send_frame(PRE_M, 24'hfedcba, 24'h012345, 2'b00, 2'b00, 2'b11, 1'b0, 0, -1, -1);

      send_pulse(3 * UI);
      repeat (100) @(negedge clk);

      check_output("missing_valid", exp_q.size(), 0);
      check_output("parity_err_count", seen_perr, exp_perr);
      check_output("final_data", data_o, last_data);
      check_output("final_lock", locked_o, (good_frames >= 2));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
